// File: rtl/pipe_ctrl.sv
// Hazard/stall/flush controller for the 5-stage RV32 pipeline, including the
// ecall/ebreak drain-and-halt sequence. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_num,
  input  logic [4:0]  id_rs2_num,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_halt_req,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd_num,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        resume,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(MEM_TIMEOUT);
  localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic             ret_drain_q, ret_drain_d;
  logic             mem_err_q, mem_err_d;

  logic dmem_stall;
  logic load_use;

  assign dmem_stall = dmem_req && !dmem_ready;
  assign load_use   = ex_valid && ex_is_load && (ex_rd_num != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_num == ex_rd_num)) ||
                       (id_uses_rs2 && (id_rs2_num == ex_rd_num)));
  assign mem_err    = mem_err_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    ret_drain_d  = ret_drain_q;
    mem_err_d    = mem_err_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (dmem_stall) begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = CNT_W'(1);
          ret_drain_d  = (state_q == ST_DRAIN);
        end else begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (ex_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else if ((state_q == ST_DRAIN) || !imem_ready) begin
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
          // The halt instr moves into EX on its entry cycle; draining starts next.
          if (state_q == ST_DRAIN) begin
            drain_cnt_d = drain_cnt_q - 3'd1;
            if (drain_cnt_q <= 3'd1) begin
              state_d = ST_HALTED;
            end
          end else if (id_halt_req && !ex_branch_taken && !load_use) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          wait_cnt_d = '0;
          state_d    = ret_drain_q ? ST_DRAIN : ST_RUN;
        end else begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
          if (wait_cnt_q == TIMEOUT) begin
            mem_err_d = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces every stage to load bubbles, independent of the clock.
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      ret_drain_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ret_drain_q <= ret_drain_d;
      mem_err_q   <= mem_err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_en && (state_q != ST_HALTED)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (id_ex_flush) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the stall/flush/halt rules.
module tb_pipe_ctrl;

  localparam int TIMEOUT = 3;
  localparam int DRAIN   = 3;
  localparam int WMAX    = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_num, id_rs2_num, ex_rd_num;
  logic        id_uses_rs1, id_uses_rs2, id_halt_req;
  logic        ex_valid, ex_is_load, ex_branch_taken;
  logic        imem_ready, dmem_req, dmem_ready, resume;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_err;
  logic [31:0] stall_cycles, flush_count;
  logic [8:0]  outs;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: draining is "drain_left > 0"; a pending dmem wait
  // returns to whatever drain progress was left.
  bit m_halted, m_waiting, m_err;
  int m_wait_len, m_drain_left;
  int unsigned m_stalls, m_flushes;

  pipe_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_num(id_rs1_num), .id_rs2_num(id_rs2_num),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_halt_req(id_halt_req), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd_num(ex_rd_num), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, mem_wb_flush, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return ex_valid && ex_is_load && ex_rd_num != 0 &&
           ((id_uses_rs1 && id_rs1_num == ex_rd_num) ||
            (id_uses_rs2 && id_rs2_num == ex_rd_num));
  endfunction

  // {pc,if_id,id_ex,ex_mem,mem_wb en ; if_id,id_ex,mem_wb flush ; halted}
  function automatic logic [8:0] model_out();
    if (m_halted)                  return 9'b00000_000_1;
    if (m_waiting)                 return dmem_ready ? 9'b11111_000_0 : 9'b00001_001_0;
    if (dmem_req && !dmem_ready)   return 9'b00001_001_0;
    if (ex_branch_taken)           return 9'b11111_110_0;
    if (hazard())                  return 9'b00111_010_0;
    if (m_drain_left > 0 || !imem_ready) return 9'b01111_100_0;
    return 9'b11111_000_0;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_waiting = 0; m_err = 0;
    m_wait_len = 0; m_drain_left = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_tick();
    logic [8:0] o;
    o = model_out();
    if (!o[8] && !m_halted) m_stalls++;
    if (o[2]) m_flushes++;
    if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (m_waiting) begin
      if (dmem_ready) begin
        m_waiting = 0; m_wait_len = 0;
      end else begin
        if (m_wait_len == TIMEOUT) m_err = 1;
        if (m_wait_len < WMAX) m_wait_len++;
      end
    end else if (dmem_req && !dmem_ready) begin
      m_waiting = 1; m_wait_len = 1;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (id_halt_req && !ex_branch_taken && !hazard()) begin
      m_drain_left = DRAIN;
    end
  endtask

  // driver tasks
  task automatic idle();
    id_rs1_num = 0; id_rs2_num = 0; ex_rd_num = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt_req = 0;
    ex_valid = 0; ex_is_load = 0; ex_branch_taken = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 1; resume = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_rd_num = rd;
    id_uses_rs1 = 1; id_rs1_num = 5;
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic cycle(input string tag);
    logic [31:0] exp_s, exp_f;
    @(negedge clk);
    check({tag, ".outs"}, {23'd0, outs}, {23'd0, model_out()});
    check({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
`ifdef PIPE_CTRL_PERF_EN
    exp_s = m_stalls; exp_f = m_flushes;
`else
    exp_s = 0; exp_f = 0;
`endif
    check({tag, ".stall_cycles"}, stall_cycles, exp_s);
    check({tag, ".flush_count"}, flush_count, exp_f);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic mid_cycle_reset();
    #2 rst = 1;
    #1;
    check("async_rst.outs", {23'd0, outs}, {23'd0, 9'b00000_111_0});
    check("async_rst.mem_err", {31'd0, mem_err}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 0;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    #2;
    check("reset.outs", {23'd0, outs}, {23'd0, 9'b00000_111_0});
    check("reset.halted", {31'd0, halted}, 32'd0);
    check("reset.stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    model_tick();
    #1;

    // Load-use on rs1, then same stimulus with rd=x0
    set_load_use(5'd5);
    #1 check("load_use.vec", {23'd0, outs}, {23'd0, 9'b00111_010_0});
    cycle("load_use");
    set_load_use(5'd0);
    #1 check("load_use_x0.vec", {23'd0, outs}, {23'd0, 9'b11111_000_0});
    cycle("load_use_x0");

    // Redirect beats load-use
    set_load_use(5'd5);
    ex_branch_taken = 1;
    #1 check("redirect.vec", {23'd0, outs}, {23'd0, 9'b11111_110_0});
    cycle("redirect");
    idle();
    cycle("idle");

    // Dmem wait four cycles, then completion
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("dmem_wait.ex_mem_en", {31'd0, ex_mem_en}, 32'd0);
      check("dmem_wait.mem_wb_flush", {31'd0, mem_wb_flush}, 32'd1);
      cycle("dmem_wait");
    end
    dmem_ready = 1;
    #1 check("dmem_done.vec", {23'd0, outs}, {23'd0, 9'b11111_000_0});
    cycle("dmem_done");
    idle();
    cycle("after_dmem");

    // Halt: one entry cycle, three drain cycles, then halted until resume
    id_halt_req = 1;
    cycle("halt_entry");
    idle();
    for (int i = 0; i < DRAIN; i++) begin
      #1 check("drain.vec", {23'd0, outs}, {23'd0, 9'b01111_100_0});
      cycle("drain");
    end
    #1 check("halted.vec", {23'd0, outs}, {23'd0, 9'b00000_000_1});
    cycle("halted");
    resume = 1; id_halt_req = 1;
    cycle("resume");
    idle();
    #1 check("resumed.vec", {23'd0, outs}, {23'd0, 9'b11111_000_0});
    cycle("resumed");

    // Timeout: dmem_ready low for ten cycles
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 10; i++) cycle("timeout");
    dmem_ready = 1;
    cycle("timeout_done");
    idle();
    cycle("err_sticky");
    check("err_sticky.mem_err", {31'd0, mem_err}, 32'd1);

    // Asynchronous reset in the middle of a dmem wait
    dmem_req = 1; dmem_ready = 0;
    cycle("pre_rst_wait");
    cycle("pre_rst_wait");
    mid_cycle_reset();
    cycle("post_rst");
    check("post_rst.mem_err", {31'd0, mem_err}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs1_num      = 5'($urandom_range(0, 3));
      id_rs2_num      = 5'($urandom_range(0, 3));
      ex_rd_num       = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_is_load      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      id_halt_req     = ($urandom_range(0, 15) == 0);
      imem_ready      = ($urandom_range(0, 3) != 0);
      dmem_req        = ($urandom_range(0, 3) == 0);
      dmem_ready      = ($urandom_range(0, 9) < 7);
      resume          = ($urandom_range(0, 3) == 0);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Hazard, stall and flush controller for the 5-stage RV32 pipeline.
- Drives enable/flush of PC, if_id, id_ex, ex_mem and mem_wb from ID/EX/MEM-stage hazard info and the imem/dmem ready handshakes.
- Sequences ecall/ebreak halt: drain pipeline, hold, resume.
- Sits in the core top beside the pipeline registers; owns no datapath.

Parameters:
MEM_TIMEOUT, 255, dmem wait cycles before mem_err sets (1..2^CNT_W-1)
CNT_W, 8, width of the dmem wait counter
DRAIN_CYCLES, 3, cycles spent draining after halt request (1..7)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
id_rs1_num  in  5  rs1 index of instr in ID
id_rs2_num  in  5  rs2 index of instr in ID
id_uses_rs1  in  1  ID instr reads rs1
id_uses_rs2  in  1  ID instr reads rs2
id_halt_req  in  1  ID instr is ecall/ebreak
ex_valid  in  1  EX holds a real instr (not bubble)
ex_is_load  in  1  EX instr is a load
ex_rd_num  in  5  EX destination index
ex_branch_taken  in  1  EX resolved taken branch/jump; PC target valid
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage issuing load/store
dmem_ready  in  1  dmem completes access this cycle
resume  in  1  leave HALTED
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble instead of input
halted  out  1  core in HALTED
mem_err  out  1  sticky dmem timeout flag
stall_cycles  out  32  perf counter (optional feature)
flush_count  out  32  perf counter (optional feature)

Behaviour:
- Outputs are combinational from state + inputs; state, counters and mem_err are flops.
- rst asserted, any time: state=RUN, wait_cnt=0, drain_cnt=0, mem_err=0, counters=0. All *_en=0, all *_flush=1, halted=0.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Priority in RUN/DRAIN, highest first:
  1. Dmem stall: dmem_req && !dmem_ready.
     - pc/if_id/id_ex/ex_mem en=0; mem_wb_en=1, mem_wb_flush=1.
     - Go to MEM_WAIT; wait_cnt=1.
  2. Redirect: ex_branch_taken.
     - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1.
     - Rest advance. Redirect beats load-use and halt request.
  3. Load-use: ex_valid && ex_is_load && ex_rd_num!=0 && ((id_uses_rs1 && id_rs1_num==ex_rd_num) || (id_uses_rs2 && id_rs2_num==ex_rd_num)).
     - pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1.
     - ex_mem/mem_wb advance. Exactly one bubble.
  4. Imem wait: !imem_ready.
     - pc_en=0; if_id_en=1, if_id_flush=1; downstream advance.
  5. Otherwise all en=1, flushes=0.
- MEM_WAIT:
  - Same outputs as dmem stall.
  - wait_cnt increments, saturating at 2^CNT_W-1.
  - When wait_cnt==MEM_TIMEOUT and still !dmem_ready: mem_err<=1 (sticky until rst); keep waiting.
  - dmem_ready=1: that cycle all en=1 (MEM result captured); return to RUN; wait_cnt=0.
- Halt entry:
  - In RUN, id_halt_req with no priority-1/2/3 condition: halt instr advances into EX.
  - Then enter DRAIN; drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - pc_en=0, if_id_en=1, if_id_flush=1 (bubbles enter); downstream advance.
  - drain_cnt decrements only on non-dmem-stall cycles. Dmem stalls go via MEM_WAIT, which returns to DRAIN, not RUN.
  - Redirect while draining is applied, stays in DRAIN.
  - drain_cnt reaching 0 -> HALTED.
- HALTED:
  - All en=0, flushes=0, halted=1.
  - resume=1 -> RUN next cycle.
  - resume and id_halt_req simultaneous in HALTED: resume wins. The halt instr was flushed as a bubble during DRAIN, so there is no re-halt.
- imem_ready is ignored in MEM_WAIT/DRAIN/HALTED.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles +1 on every cycle with pc_en=0 outside HALTED.
  - flush_count +1 on every cycle with id_ex_flush=1.
  - Both wrap at 2^32; reset to 0.
- Undefined: ports present, tied to 0, no counter flops.

Test Plan:
- Load-use: ex_valid=1, ex_is_load=1, ex_rd_num=5, id_uses_rs1=1, id_rs1_num=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_rd_num=0 same stimulus -> no stall.
- Redirect + load-use simultaneous: ex_branch_taken=1 with above hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_count +1.
- Dmem wait: dmem_req=1, dmem_ready low 4 cycles -> ex_mem_en=0, mem_wb_flush=1 for 4 cycles, cycle 5 all en=1, state RUN; stall_cycles=4.
- Timeout, MEM_TIMEOUT=3: dmem_ready low 10 cycles -> mem_err rises on 3rd wait cycle, stays 1 after dmem_ready; clears only on rst.
- Halt: id_halt_req pulse -> 3 drain cycles of if_id_flush=1, then halted=1 with all en=0; resume=1 -> next cycle RUN, all en=1.
- Async reset mid-MEM_WAIT: rst asserted between clock edges -> outputs immediately en=0, flush=1; after release state RUN, mem_err=0.
